gold_gen_mc: RTL and testbench

Multi-channel, parametrised Gold code generator and successor to Gold_gen. One shared reference m-sequence (LFSR1) is XORed with NUM_CH independent LFSR2 instances, each advanced by a per-channel phase offset during a deterministic alignment phase. Output is a NUM_CH-bit chip vector per sample, with a runtime chip hold (samples per chip), a valid/ready output handshake with backpressure, and an epoch marker. It sits between the configuration/control logic and the spreading/correlation datapath.

---
 rtl/gold_pkg.sv | 12 +
 rtl/gold_lfsr.sv | 24 ++
 rtl/gold_gen_mc.sv | 108 ++++++++++
 tb/tb_gold_gen_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gold_pkg.sv
// Shared types and defaults for the multi-channel Gold code generator.
package gold_pkg;
  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_e;

  localparam int         DEF_DEGREE = 6;
  localparam logic [5:0] DEF_POLY1  = 6'b000011;
  localparam logic [5:0] DEF_POLY2  = 6'b100111;

  function automatic int code_len(input int degree);
    return (1 << degree) - 1;
  endfunction
endpackage

// File: rtl/gold_lfsr.sv
// Fibonacci LFSR with all-ones seed load; output chip is the LSB.
module gold_lfsr
  import gold_pkg::*;
#(
  parameter int               DEGREE = DEF_DEGREE,
  parameter logic [DEGREE-1:0] POLY  = DEGREE'(DEF_POLY1)
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              seed_load_i,
  input  logic              step_i,
  output logic [DEGREE-1:0] state_o,
  output logic              out_o
);
  logic [DEGREE-1:0] s_q;

  always_ff @(posedge clkin) begin
    if (rst || seed_load_i) s_q <= '1;
    else if (step_i)        s_q <= {^(s_q & POLY), s_q[DEGREE-1:1]};
  end

  assign state_o = s_q;
  assign out_o   = s_q[0];
endmodule

// File: rtl/gold_gen_mc.sv
// Multi-channel Gold code generator: shared LFSR1 XORed with per-channel
// phase-aligned LFSR2 copies, with chip hold and valid/ready output.
module gold_gen_mc
  import gold_pkg::*;
#(
  parameter int                DEGREE = DEF_DEGREE,
  parameter int                NUM_CH = 2,
  parameter logic [DEGREE-1:0] POLY1  = DEGREE'(DEF_POLY1),
  parameter logic [DEGREE-1:0] POLY2  = DEGREE'(DEF_POLY2),
  parameter int                HOLD_W = 4
) (
  input  logic                     clkin,
  input  logic                     rst,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [NUM_CH*DEGREE-1:0] cfg_phase_i,
  input  logic [HOLD_W-1:0]        cfg_hold_i,
  input  logic                     stop_i,
  output logic                     ready_o,
  output logic                     tvalid_o,
  input  logic                     tready_i,
  output logic [NUM_CH-1:0]        code_o,
  output logic                     epoch_o
);
  localparam int                LEN       = code_len(DEGREE);
  localparam logic [DEGREE-1:0] LAST_K    = DEGREE'(LEN - 2);
  localparam logic [DEGREE-1:0] LAST_CHIP = DEGREE'(LEN - 1);

  state_e                         state_q;
  logic [DEGREE-1:0]              k_q, chip_cnt_q;
  logic [HOLD_W-1:0]              hold_q, hold_cnt_q, hold_max;
  logic [NUM_CH-1:0][DEGREE-1:0]  phase_q;

  logic                           run, cfg_hs, xfer, chip_end, chip_step, l1_out;
  logic [NUM_CH-1:0]              l2_out, align_step;
  logic [NUM_CH:0][DEGREE-1:0]    lfsr_st_unused;

  assign run         = (state_q == RUN);
  assign cfg_ready_o = (state_q != ALIGN);
  assign cfg_hs      = cfg_valid_i & cfg_ready_o;
  assign hold_max    = (hold_q == '0) ? HOLD_W'(1) : hold_q;
  assign chip_end    = (hold_cnt_q == hold_max - HOLD_W'(1));
  // a reconfig in RUN pre-empts the sample offered in the same cycle
  assign xfer        = run & tready_i & ~cfg_hs;
  assign chip_step   = xfer & chip_end;

  assign ready_o  = run;
  assign tvalid_o = run;
  assign epoch_o  = run & (chip_cnt_q == '0);

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      chip_cnt_q <= '0;
      hold_cnt_q <= '0;
      hold_q     <= '0;
      phase_q    <= '0;
    end else if (cfg_hs) begin
      state_q    <= ALIGN;
      k_q        <= '0;
      chip_cnt_q <= '0;
      hold_cnt_q <= '0;
      hold_q     <= cfg_hold_i;
      // offset LEN is a full period, i.e. the same as no offset
      for (int c = 0; c < NUM_CH; c++)
        phase_q[c] <= (cfg_phase_i[c*DEGREE +: DEGREE] == '1) ? '0
                                                              : cfg_phase_i[c*DEGREE +: DEGREE];
    end else if (stop_i && state_q != IDLE) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        ALIGN: begin
          k_q <= k_q + DEGREE'(1);
          if (k_q == LAST_K) state_q <= RUN;
        end
        RUN: begin
          if (xfer) begin
            if (chip_end) begin
              hold_cnt_q <= '0;
              chip_cnt_q <= (chip_cnt_q == LAST_CHIP) ? '0 : chip_cnt_q + DEGREE'(1);
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  gold_lfsr #(.DEGREE(DEGREE), .POLY(POLY1)) u_lfsr1 (
    .clkin(clkin), .rst(rst), .seed_load_i(cfg_hs), .step_i(chip_step),
    .state_o(lfsr_st_unused[0]), .out_o(l1_out)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign align_step[c] = (state_q == ALIGN) && (k_q < phase_q[c]);

    gold_lfsr #(.DEGREE(DEGREE), .POLY(POLY2)) u_lfsr2 (
      .clkin(clkin), .rst(rst), .seed_load_i(cfg_hs),
      .step_i(chip_step | align_step[c]),
      .state_o(lfsr_st_unused[c+1]), .out_o(l2_out[c])
    );

    assign code_o[c] = run & (l1_out ^ l2_out[c]);
  end
endmodule

// File: tb/tb_gold_gen_mc.sv
// Bench for gold_gen_mc: config table plus random tready, checked against a sequence model.
module tb_gold_gen_mc;
  localparam int         DEGREE = 6;
  localparam int         NUM_CH = 2;
  localparam int         HOLD_W = 4;
  localparam int         LEN    = 63;
  localparam logic [5:0] P1     = 6'b000011;
  localparam logic [5:0] P2     = 6'b100111;

  logic                     clkin = 0;
  logic                     rst = 1;
  logic                     cfg_valid_i = 0;
  logic                     cfg_ready_o;
  logic [NUM_CH*DEGREE-1:0] cfg_phase_i = '0;
  logic [HOLD_W-1:0]        cfg_hold_i = '0;
  logic                     stop_i = 0;
  logic                     ready_o, tvalid_o, epoch_o;
  logic                     tready_i = 0;
  logic [NUM_CH-1:0]        code_o;

  gold_gen_mc #(.DEGREE(DEGREE), .NUM_CH(NUM_CH), .POLY1(P1), .POLY2(P2), .HOLD_W(HOLD_W)) dut (
    .clkin(clkin), .rst(rst), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_phase_i(cfg_phase_i), .cfg_hold_i(cfg_hold_i), .stop_i(stop_i), .ready_o(ready_o),
    .tvalid_o(tvalid_o), .tready_i(tready_i), .code_o(code_o), .epoch_o(epoch_o)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int p0, p1, h, n;
    bit rnd;
    int exp_lat;
    bit exp_eq;
    bit chk_ones;
  } vec_t;

  int           n_cmp = 0, n_err = 0;
  logic [LEN-1:0] m1, m2;
  int           cur_p[NUM_CH];
  int           cur_h, xf, ones;
  bit           eq_all;
  vec_t         tbl[8];

  // m-sequence from the recurrence a[n+D] = XOR of a[n+i] for each tap i
  function automatic logic [LEN-1:0] mseq(input logic [DEGREE-1:0] poly);
    logic [LEN+DEGREE-1:0] a;
    logic fb;
    a = '0;
    a[DEGREE-1:0] = '1;
    for (int n = 0; n < LEN; n++) begin
      fb = 1'b0;
      for (int i = 0; i < DEGREE; i++) if (poly[i]) fb ^= a[n+i];
      a[n+DEGREE] = fb;
    end
    return a[LEN-1:0];
  endfunction

  function automatic logic [NUM_CH-1:0] exp_code(input int x);
    logic [NUM_CH-1:0] r;
    int j;
    j = (x / cur_h) % LEN;
    for (int c = 0; c < NUM_CH; c++) r[c] = m1[j] ^ m2[(j + cur_p[c]) % LEN];
    return r;
  endfunction

  function automatic logic exp_epoch(input int x);
    return ((x / cur_h) % LEN) == 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (xfer %0d, t=%0t)", nm, act, exp, xf, $time);
    end
  endtask

  task automatic do_cfg(input int p0, input int p1, input int h, input bit stp, input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clkin);
    chk("cfg_ready_pre", int'(cfg_ready_o), 1);
    cfg_phase_i = {6'(p1), 6'(p0)};
    cfg_hold_i  = 4'(h);
    cfg_valid_i = 1;
    stop_i      = stp;
    tready_i    = 0;
    @(posedge clkin);
    #1;
    cfg_valid_i = 0;
    stop_i      = 0;
    cur_p[0] = (p0 == LEN) ? 0 : p0;
    cur_p[1] = (p1 == LEN) ? 0 : p1;
    cur_h    = (h == 0) ? 1 : h;
    xf       = 0;
    @(negedge clkin);
    chk("align_cfg_ready", int'(cfg_ready_o), 0);
    while (!tvalid_o && lat < 300) begin
      @(negedge clkin);
      lat++;
    end
    chk("align_len", lat, exp_lat);
  endtask

  task automatic run_xfers(input int n, input bit rnd);
    int cyc, done;
    cyc = 0; done = 0; ones = 0; eq_all = 1;
    while (done < n) begin
      if (cyc > 8*n + 20) begin
        chk("xfer_timeout", done, n);
        break;
      end
      chk("tvalid", int'(tvalid_o), 1);
      chk("code", int'(code_o), int'(exp_code(xf)));
      chk("epoch", int'(epoch_o), int'(exp_epoch(xf)));
      if (code_o[0] !== code_o[1]) eq_all = 0;
      tready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tready_i && xf < LEN) ones += int'(code_o[0]);
      @(posedge clkin);
      if (tready_i) begin xf++; done++; end
      @(negedge clkin);
      cyc++;
    end
    tready_i = 0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_tvalid"}, int'(tvalid_o), 0);
    chk({nm, "_epoch"}, int'(epoch_o), 0);
    chk({nm, "_code"}, int'(code_o), 0);
    chk({nm, "_cfg_ready"}, int'(cfg_ready_o), 1);
    chk({nm, "_ready"}, int'(ready_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  initial begin
    m1 = mseq(P1);
    m2 = mseq(P2);
    cur_h = 1; xf = 0; cur_p[0] = 0; cur_p[1] = 0;

    tbl[0] = '{p0: 0,  p1: 0,  h: 1, n: 190, rnd: 0, exp_lat: LEN-1, exp_eq: 1, chk_ones: 1};
    tbl[1] = '{p0: 0,  p1: 5,  h: 1, n: 126, rnd: 0, exp_lat: LEN-1, exp_eq: 0, chk_ones: 0};
    tbl[2] = '{p0: 63, p1: 5,  h: 1, n: 126, rnd: 1, exp_lat: LEN-1, exp_eq: 0, chk_ones: 0};
    tbl[3] = '{p0: 7,  p1: 40, h: 3, n: 200, rnd: 1, exp_lat: LEN-1, exp_eq: 0, chk_ones: 0};
    tbl[4] = '{p0: 0,  p1: 0,  h: 0, n: 130, rnd: 1, exp_lat: LEN-1, exp_eq: 1, chk_ones: 0};
    tbl[5] = '{p0: 63, p1: 0,  h: 2, n: 60,  rnd: 1, exp_lat: LEN-1, exp_eq: 1, chk_ones: 0};
    for (int i = 6; i < 8; i++)
      tbl[i] = '{p0: int'($urandom_range(0, 63)), p1: int'($urandom_range(0, 63)),
                 h: int'($urandom_range(0, 5)), n: 140, rnd: 1, exp_lat: LEN-1,
                 exp_eq: 0, chk_ones: 0};

    repeat (3) @(posedge clkin);
    @(negedge clkin);
    rst = 0;
    chk_idle_outputs("por");

    for (int i = 0; i < 8; i++) begin
      do_cfg(tbl[i].p0, tbl[i].p1, tbl[i].h, 1'b0, tbl[i].exp_lat);
      run_xfers(tbl[i].n, tbl[i].rnd);
      if (tbl[i].exp_eq) chk("ch_equal", int'(eq_all), 1);
      if (tbl[i].chk_ones) begin
        n_cmp++;
        if (!(ones == 24 || ones == 32 || ones == 40)) begin
          n_err++;
          $display("FAIL ones_count: got %0d, required 24, 32 or 40", ones);
        end
      end
    end

    // reconfig with simultaneous stop: config must win
    do_cfg(1, 2, 1, 1'b1, LEN-1);
    chk("restart_epoch", int'(epoch_o), 1);
    run_xfers(70, 1'b1);

    // stop alone
    @(negedge clkin);
    stop_i = 1;
    @(posedge clkin);
    #1 stop_i = 0;
    @(negedge clkin);
    chk("stop_tvalid", int'(tvalid_o), 0);
    chk("stop_ready", int'(ready_o), 0);
    chk("stop_cfg_ready", int'(cfg_ready_o), 1);

    // reset held 3 cycles mid-RUN, then recovery
    do_cfg(4, 9, 2, 1'b0, LEN-1);
    run_xfers(25, 1'b1);
    @(negedge clkin);
    rst = 1;
    repeat (3) @(posedge clkin);
    @(negedge clkin);
    rst = 0;
    chk_idle_outputs("rst");
    do_cfg(3, 9, 2, 1'b0, LEN-1);
    run_xfers(50, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
